vga_sync_rx: RTL and testbench

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

---
 rtl/vga_sync_rx_pkg.sv | 32 +++
 rtl/vga_edge_det.sv | 19 +
 rtl/vga_sync_rx.sv | 169 ++++++++++++++++
 tb/tb_vga_sync_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_rx_pkg.sv
// Shared VGA timing constants and receiver FSM state type.
// Also used by the matching sync generator.
package vga_sync_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    LINE_LOCK,
    FRAME_CHK,
    LOCKED
  } state_t;

  localparam int H_TOTAL = 1525;
  localparam int V_TOTAL = 525;

  localparam int H_ACTIVE_DEF = 1220;
  localparam int H_START_DEF  = H_TOTAL - H_ACTIVE_DEF - 31;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_START_DEF  = V_TOTAL - V_ACTIVE_DEF - 11;
  localparam int H_TOL_DEF    = 2;
  localparam int LOCK_DEF     = 4;

  localparam logic [10:0] HCNT_MAX = 11'h7ff;
  localparam logic [9:0]  VCNT_MAX = 10'h3ff;

  function automatic logic [11:0] absdiff12(
    input logic [11:0] a,
    input logic [11:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Falling-edge detector on a synchronous active-low strobe.
// History resets high so a low input at reset is not an edge.
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= sig;
  end

  assign fall = prev & ~sig;

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame timing, locks,
// and emits active-area pixels with coordinates.
module vga_sync_rx
  import vga_sync_rx_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_START    = H_START_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_START    = V_START_DEF,
  parameter int H_TOL      = H_TOL_DEF,
  parameter int LOCK_LINES = LOCK_DEF
) (
  input  logic        clk48,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [1:0]  r_in,
  input  logic [1:0]  g_in,
  input  logic [1:0]  b_in,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines
);

  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE - 1);
  localparam logic [9:0]  V_LO = 10'(V_START);
  localparam logic [9:0]  V_HI = 10'(V_START + V_ACTIVE - 1);
  localparam logic [11:0] TOL  = 12'(H_TOL);
  localparam logic [7:0]  M_LAST = 8'(LOCK_LINES - 1);

  logic        h_fall;
  logic        v_fall;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic [7:0]  mcnt;
  logic [7:0]  mcnt_n;
  state_t      state;
  state_t      state_n;
  logic        err_n;
  logic [11:0] len_cur;
  logic [11:0] dev;
  logic [9:0]  lines_cur;
  logic        match;
  logic        h_sat;
  logic        v_sat;
  logic        frame_eq;
  logic        active;

  vga_edge_det u_h (
    .clk  (clk48),
    .rst  (rst),
    .sig  (hsync),
    .fall (h_fall)
  );

  vga_edge_det u_v (
    .clk  (clk48),
    .rst  (rst),
    .sig  (vsync),
    .fall (v_fall)
  );

  // 12-bit so a saturated count cannot wrap into a false match
  assign len_cur   = {1'b0, hcnt} + 12'd1;
  assign dev       = absdiff12(len_cur, {1'b0, line_len});
  assign match     = dev <= TOL;
  assign h_sat     = hcnt == HCNT_MAX;
  assign v_sat     = vcnt == VCNT_MAX;
  assign lines_cur = vcnt + 10'd1;
  assign frame_eq  = lines_cur == frame_lines;

  always_ff @(posedge clk48) begin
    if (rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      if (h_fall)      hcnt <= '0;
      else if (!h_sat) hcnt <= hcnt + 11'd1;
      if (v_fall)
        vcnt <= '0;
      else if (h_fall && !v_sat)
        vcnt <= vcnt + 10'd1;
      if (h_fall && !h_sat) line_len <= len_cur[10:0];
      if (v_fall) frame_lines <= lines_cur;
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state  <= SEARCH;
      mcnt   <= '0;
      err    <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_n;
      mcnt   <= mcnt_n;
      err    <= err_n;
      locked <= state_n == LOCKED;
    end
  end

  always_comb begin
    state_n = state;
    mcnt_n  = mcnt;
    err_n   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (h_fall) begin
          if (!match) begin
            mcnt_n = '0;
          end else if (mcnt == M_LAST) begin
            mcnt_n  = '0;
            state_n = LINE_LOCK;
          end else begin
            mcnt_n = mcnt + 8'd1;
          end
        end
      end
      LINE_LOCK: if (v_fall) state_n = FRAME_CHK;
      FRAME_CHK: if (v_fall && frame_eq) state_n = LOCKED;
      LOCKED: begin
        if (v_fall && !frame_eq) begin
          state_n = FRAME_CHK;
          err_n   = 1'b1;
        end
      end
      default: state_n = SEARCH;
    endcase
    // timing loss overrides any frame-level decision
    if (state != SEARCH &&
        ((h_fall && !match) || h_sat || v_sat)) begin
      state_n = SEARCH;
      mcnt_n  = '0;
      err_n   = 1'b1;
    end
  end

  assign active = state == LOCKED &&
                  vcnt >= V_LO && vcnt <= V_HI &&
                  hcnt >= H_LO && hcnt <= H_HI;

  always_ff @(posedge clk48) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
    end else begin
      pix_valid   <= active;
      frame_start <= active && hcnt == H_LO && vcnt == V_LO;
      if (active) begin
        pix_x   <= hcnt - H_LO;
        pix_y   <= vcnt - V_LO;
        pix_rgb <= {r_in, g_in, b_in};
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a shrunken 20x8 timing
// with an 8x3 active window at (6,2).
module tb_vga_sync_rx;

  localparam int HA  = 8;
  localparam int HS  = 6;
  localparam int VA  = 3;
  localparam int VS  = 2;
  localparam int HT  = 20;
  localparam int HSW = 4;
  localparam int VSW = 2;

  logic        clk48 = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [1:0]  r_in = '0;
  logic [1:0]  g_in = '0;
  logic [1:0]  b_in = '0;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [5:0]  pix_rgb;
  logic        frame_start;
  logic        locked;
  logic        err;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;

  vga_sync_rx #(
    .H_ACTIVE   (HA),
    .H_START    (HS),
    .V_ACTIVE   (VA),
    .V_START    (VS),
    .H_TOL      (2),
    .LOCK_LINES (4)
  ) dut (
    .clk48       (clk48),
    .rst         (rst),
    .hsync       (hsync),
    .vsync       (vsync),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .locked      (locked),
    .err         (err),
    .line_len    (line_len),
    .frame_lines (frame_lines)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    int len;
    int lk;
    int er;
    int ln;
  } vec_t;

  int total = 0;
  int bad = 0;
  int s_locked, s_err, s_err2, s_len, s_flines;
  int pvcnt, errcnt, err_at, pixbad, fscnt;
  int r_pv, r_lk, r_px, r_py, r_rgb, r_len, r_fl, r_fs;
  bit chk = 1'b0;
  vec_t tab [8];

  task automatic check(input string name,
                       input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One line: edge cycle first, hsync low HSW clocks.
  // Sample taken #1 after each edge reflects that cycle.
  task automatic run_line(input int len, input bit vlow,
                          input int j, input int rst_at);
    logic [5:0] pv;
    int hc;
    bit ex;
    for (int i = 0; i < len; i++) begin
      hsync = (i >= HSW);
      vsync = ~vlow;
      pv = 6'(i - 1);
      {r_in, g_in, b_in} = pv;
      rst = (i == rst_at);
      @(posedge clk48);
      #1;
      rst = 1'b0;
      if (i == rst_at) begin
        r_pv = pix_valid; r_lk = locked;
        r_px = pix_x; r_py = pix_y;
        r_rgb = pix_rgb; r_len = line_len;
        r_fl = frame_lines; r_fs = frame_start;
        pvcnt = 0;
      end
      if (i == 0) begin
        s_locked = locked; s_err = err;
        s_len = line_len; s_flines = frame_lines;
      end
      if (i == 1) s_err2 = err;
      if (pix_valid) pvcnt++;
      if (err) begin
        errcnt++;
        if (err_at < 0) err_at = i;
      end
      if (chk) begin
        hc = i - 1;
        ex = j >= VS && j < VS + VA &&
             hc >= HS && hc < HS + HA;
        if (pix_valid != ex) pixbad++;
        else if (ex && (pix_x != 11'(hc - HS) ||
                 pix_y != 10'(j - VS) ||
                 pix_rgb != pv)) pixbad++;
        if (frame_start) begin
          fscnt++;
          if (!(ex && hc == HS && j == VS)) pixbad++;
        end
      end
    end
  endtask

  task automatic run_frame(input int first, input int last,
                           input int long_j, input int long_len);
    for (int j = first; j < last; j++)
      run_line(j == long_j ? long_len : HT, j < VSW, j, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tab = '{'{19, 1, 0, 19}, '{21, 1, 0, 21},
            '{19, 1, 0, 19}, '{21, 1, 0, 21},
            '{20, 1, 0, 20}, '{20, 1, 0, 20},
            '{22, 1, 0, 22}, '{20, 1, 0, 20}};
    pvcnt = 0; errcnt = 0; err_at = -1;
    pixbad = 0; fscnt = 0;

    repeat (3) @(posedge clk48);
    #1;
    check("rst_locked", locked, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_err", err, 0);
    check("rst_fs", frame_start, 0);
    check("rst_len", line_len, 0);
    check("rst_flines", frame_lines, 0);
    check("rst_px", pix_x, 0);
    check("rst_py", pix_y, 0);
    check("rst_rgb", pix_rgb, 0);

    // acquisition: lock lands at the third frame edge
    run_frame(0, 8, -1, 0);
    run_frame(0, 8, -1, 0);
    check("acq_not_yet", locked, 0);
    check("acq_no_pix", pvcnt, 0);
    pvcnt = 0;
    chk = 1'b1;
    run_line(HT, 1'b1, 0, -1);
    check("acq_locked", s_locked, 1);
    check("acq_flines", s_flines, 8);
    check("acq_len", s_len, 20);
    run_frame(1, 8, -1, 0);
    chk = 1'b0;
    check("frm_pixcnt", pvcnt, HA * VA);
    check("frm_pixbad", pixbad, 0);
    check("frm_fscnt", fscnt, 1);
    check("hold_valid", pix_valid, 0);
    check("hold_px", pix_x, HA - 1);
    check("hold_py", pix_y, VA - 1);
    check("hold_rgb", pix_rgb, HS + HA - 1);

    // jitter within tolerance keeps lock
    errcnt = 0;
    for (int k = 0; k < 8; k++) begin
      run_line(tab[k].len, k < VSW, k, -1);
      if (k > 0) begin
        check("tab_locked", s_locked, tab[k-1].lk);
        check("tab_err", s_err, tab[k-1].er);
        check("tab_len", s_len, tab[k-1].ln);
      end
    end
    run_line(HT, 1'b1, 0, -1);
    check("tab_locked", s_locked, tab[7].lk);
    check("tab_err", s_err, tab[7].er);
    check("tab_len", s_len, tab[7].ln);
    check("jit_errcnt", errcnt, 0);

    // one 25-clk line breaks lock, then relock
    errcnt = 0;
    run_frame(1, 4, 3, 25);
    run_line(HT, 1'b0, 4, -1);
    check("bad_err", s_err, 1);
    check("bad_locked", s_locked, 0);
    check("bad_len", s_len, 25);
    check("bad_err_1cyc", s_err2, 0);
    run_frame(5, 8, -1, 0);
    check("bad_errcnt", errcnt, 1);
    run_frame(0, 8, -1, 0);
    run_frame(0, 8, -1, 0);
    check("relock_wait", locked, 0);
    run_line(HT, 1'b1, 0, -1);
    check("relock", s_locked, 1);

    // reset in the middle of active pixel (3,1)
    run_frame(1, 3, -1, 0);
    run_line(HT, 1'b0, 3, 10);
    check("mrst_valid", r_pv, 0);
    check("mrst_locked", r_lk, 0);
    check("mrst_px", r_px, 0);
    check("mrst_py", r_py, 0);
    check("mrst_rgb", r_rgb, 0);
    check("mrst_len", r_len, 0);
    check("mrst_flines", r_fl, 0);
    check("mrst_fs", r_fs, 0);
    run_frame(4, 8, -1, 0);
    run_frame(0, 8, -1, 0);
    run_frame(0, 8, -1, 0);
    check("mrst_unlocked", locked, 0);
    check("mrst_no_pix", pvcnt, 0);
    run_line(HT, 1'b1, 0, -1);
    check("mrst_relock", s_locked, 1);

    // 9-line frame while locked
    run_frame(1, 9, -1, 0);
    run_line(HT, 1'b1, 0, -1);
    check("fl_err", s_err, 1);
    check("fl_locked", s_locked, 0);
    check("fl_flines", s_flines, 9);
    run_frame(1, 8, -1, 0);
    run_line(HT, 1'b1, 0, -1);
    check("fl_chk_err", s_err, 0);
    check("fl_chk_locked", s_locked, 0);
    check("fl_chk_flines", s_flines, 8);
    run_frame(1, 8, -1, 0);
    run_line(HT, 1'b1, 0, -1);
    check("fl_relock", s_locked, 1);

    // hcnt saturation on an overlong line
    errcnt = 0;
    err_at = -1;
    run_line(2100, 1'b1, 1, -1);
    check("sat_errcnt", errcnt, 1);
    check("sat_err_at", err_at, 2048);
    check("sat_locked", locked, 0);
    run_line(HT, 1'b0, 2, -1);
    check("sat_len_kept", s_len, 20);
    check("sat_search", s_locked, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
